saes32_issue_ctrl: RTL and testbench

- Issue-side controller for the masked saes32 functional unit; it sits between the core's coprocessor request/writeback path and the FU.
- Accepts saes32 requests and registers them toward the FU with fresh 26-bit randomness from an internal LFSR.
- Tracks in-flight instruction IDs, checks returned IDs, and buffers results so the FU output is never back-pressured.
- Returns results to the core in order over a valid/ready writeback handshake.

---
 rtl/saes32_issue_ctrl_if.sv | 59 +++++
 rtl/saes32_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_saes32_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/saes32_issue_ctrl_if.sv
// Handshake bundle between the core request/writeback path, the issue controller and the saes32 FU.
// Signal suffixes are named from the controller's point of view (slave modport).
interface saes32_issue_ctrl_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [31:0]           req_rs1_i;
  logic [31:0]           req_rs2_i;
  logic [1:0]            req_bs_i;
  logic [1:0]            req_op_i;
  logic [X_ID_WIDTH-1:0] req_id_i;

  logic                  fu_valid_o;
  logic                  fu_ready_i;
  logic [31:0]           fu_rs1_o;
  logic [31:0]           fu_rs2_o;
  logic [1:0]            fu_bs_o;
  logic [25:0]           fu_randombits_o;
  logic [X_ID_WIDTH-1:0] fu_instr_id_o;
  logic                  fu_op_encs_o;
  logic                  fu_op_encsm_o;
  logic                  fu_op_decs_o;
  logic                  fu_op_decsm_o;

  logic                  fu_valid_i;
  logic                  fu_ready_o;
  logic [31:0]           fu_result_i;
  logic [X_ID_WIDTH-1:0] fu_instr_id_i;

  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [31:0]           res_data_o;
  logic [X_ID_WIDTH-1:0] res_id_o;

  modport slave (
    input  req_valid_i, req_rs1_i, req_rs2_i, req_bs_i, req_op_i, req_id_i,
    output req_ready_o,
    output fu_valid_o, fu_rs1_o, fu_rs2_o, fu_bs_o, fu_randombits_o, fu_instr_id_o,
    output fu_op_encs_o, fu_op_encsm_o, fu_op_decs_o, fu_op_decsm_o,
    input  fu_ready_i,
    input  fu_valid_i, fu_result_i, fu_instr_id_i,
    output fu_ready_o,
    output res_valid_o, res_data_o, res_id_o,
    input  res_ready_i
  );

  modport master (
    output req_valid_i, req_rs1_i, req_rs2_i, req_bs_i, req_op_i, req_id_i,
    input  req_ready_o,
    input  fu_valid_o, fu_rs1_o, fu_rs2_o, fu_bs_o, fu_randombits_o, fu_instr_id_o,
    input  fu_op_encs_o, fu_op_encsm_o, fu_op_decs_o, fu_op_decsm_o,
    output fu_ready_i,
    output fu_valid_i, fu_result_i, fu_instr_id_i,
    input  fu_ready_o,
    input  res_valid_o, res_data_o, res_id_o,
    output res_ready_i
  );
endinterface

// File: rtl/saes32_issue_ctrl.sv
// Issue controller for the masked saes32 FU: credit-limited issue with LFSR randomness, ID tracking, in-order result buffer.
// Optional macro SAES32_ISSUE_RESEED_EN adds reseed_i/seed_i for runtime LFSR reseeding.
module saes32_issue_ctrl #(
  parameter int          X_ID_WIDTH = 4,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  saes32_issue_ctrl_if.slave    bus,
`ifdef SAES32_ISSUE_RESEED_EN
  input  logic                  reseed_i,
  input  logic [31:0]           seed_i,
`endif
  output logic                  busy_o,
  output logic                  id_err_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [3:0] op_decode(input logic [1:0] op);
    op_decode = 4'b0001 << op;
  endfunction

  // LFSR
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
`ifdef SAES32_ISSUE_RESEED_EN
    if (reseed_i) lfsr_d = (seed_i == 32'h0) ? LFSR_SEED : seed_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  // Issue register and credit counter
  logic                  fu_valid_q;
  logic [31:0]           fu_rs1_q, fu_rs2_q;
  logic [1:0]            fu_bs_q;
  logic [25:0]           fu_rnd_q;
  logic [X_ID_WIDTH-1:0] fu_id_q;
  logic [3:0]            fu_op_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready, accept;

  assign req_ready = (!fu_valid_q || bus.fu_ready_i) && (cnt_q < CW'(DEPTH));
  assign accept    = bus.req_valid_i && req_ready;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fu_valid_q <= 1'b0;
      fu_rs1_q   <= '0;
      fu_rs2_q   <= '0;
      fu_bs_q    <= '0;
      fu_rnd_q   <= '0;
      fu_id_q    <= '0;
      fu_op_q    <= '0;
    end else if (accept) begin
      fu_valid_q <= 1'b1;
      fu_rs1_q   <= bus.req_rs1_i;
      fu_rs2_q   <= bus.req_rs2_i;
      fu_bs_q    <= bus.req_bs_i;
      fu_rnd_q   <= lfsr_q[25:0];
      fu_id_q    <= bus.req_id_i;
      fu_op_q    <= op_decode(bus.req_op_i);
    end else if (bus.fu_ready_i) begin
      fu_valid_q <= 1'b0;
    end
  end

  // ID FIFO: IDs in issue order, popped as the FU returns results
  logic [X_ID_WIDTH-1:0] idf_mem [DEPTH];
  logic [AW:0]           idf_wr_q, idf_rd_q;
  logic                  idf_empty, id_pop, id_mismatch;

  assign idf_empty   = (idf_wr_q == idf_rd_q);
  assign id_pop      = bus.fu_valid_i && !idf_empty;
  assign id_mismatch = bus.fu_valid_i &&
                       (idf_empty || (idf_mem[idf_rd_q[AW-1:0]] != bus.fu_instr_id_i));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      idf_wr_q <= '0;
      idf_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) idf_mem[i] <= '0;
    end else begin
      if (accept) begin
        idf_mem[idf_wr_q[AW-1:0]] <= bus.req_id_i;
        idf_wr_q                  <= idf_wr_q + (AW+1)'(1);
      end
      if (id_pop) idf_rd_q <= idf_rd_q + (AW+1)'(1);
    end
  end

  // Result FIFO: head entry drives the writeback port directly
  logic [31:0]           rf_data_mem [DEPTH];
  logic [X_ID_WIDTH-1:0] rf_id_mem   [DEPTH];
  logic [AW:0]           rf_wr_q, rf_rd_q;
  logic                  rf_empty, rf_full, rf_push, res_pop;

  assign rf_empty = (rf_wr_q == rf_rd_q);
  assign rf_full  = (rf_wr_q[AW] != rf_rd_q[AW]) && (rf_wr_q[AW-1:0] == rf_rd_q[AW-1:0]);
  assign res_pop  = !rf_empty && bus.res_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the FU result.
  assign rf_push  = id_pop && (!rf_full || res_pop);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_q <= '0;
      rf_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rf_data_mem[i] <= '0;
        rf_id_mem[i]   <= '0;
      end
    end else begin
      if (rf_push) begin
        rf_data_mem[rf_wr_q[AW-1:0]] <= bus.fu_result_i;
        rf_id_mem[rf_wr_q[AW-1:0]]   <= bus.fu_instr_id_i;
        rf_wr_q                      <= rf_wr_q + (AW+1)'(1);
      end
      if (res_pop) rf_rd_q <= rf_rd_q + (AW+1)'(1);
    end
  end

  // Credits and sticky error
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, res_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  logic id_err_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      id_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (id_mismatch) id_err_q <= 1'b1;
    end
  end

  assign bus.req_ready_o     = req_ready;
  assign bus.fu_valid_o      = fu_valid_q;
  assign bus.fu_rs1_o        = fu_rs1_q;
  assign bus.fu_rs2_o        = fu_rs2_q;
  assign bus.fu_bs_o         = fu_bs_q;
  assign bus.fu_randombits_o = fu_rnd_q;
  assign bus.fu_instr_id_o   = fu_id_q;
  assign bus.fu_op_encs_o    = fu_op_q[0];
  assign bus.fu_op_encsm_o   = fu_op_q[1];
  assign bus.fu_op_decs_o    = fu_op_q[2];
  assign bus.fu_op_decsm_o   = fu_op_q[3];
  assign bus.fu_ready_o      = !rf_full;
  assign bus.res_valid_o     = !rf_empty;
  assign bus.res_data_o      = rf_data_mem[rf_rd_q[AW-1:0]];
  assign bus.res_id_o        = rf_id_mem[rf_rd_q[AW-1:0]];
  assign busy_o              = (cnt_q != '0);
  assign id_err_o            = id_err_q;

endmodule

// File: tb/tb_saes32_issue_ctrl.sv
// Directed bench for saes32_issue_ctrl with a one-cycle FU model and an LFSR reference.
// The FU model uses real S-box values for a zero source byte and b^8'hA5 as a stand-in otherwise.
module tb_saes32_issue_ctrl;
  localparam int          XW    = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] SEED  = 32'hACE12468;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  saes32_issue_ctrl_if #(.X_ID_WIDTH(XW)) bus ();
  logic busy_o, id_err_o;
`ifdef SAES32_ISSUE_RESEED_EN
  logic        reseed_i = 1'b0;
  logic [31:0] seed_i   = 32'h0;
`endif

  saes32_issue_ctrl #(.X_ID_WIDTH(XW), .DEPTH(DEPTH), .LFSR_SEED(SEED)) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .bus     (bus),
`ifdef SAES32_ISSUE_RESEED_EN
    .reseed_i(reseed_i),
    .seed_i  (seed_i),
`endif
    .busy_o  (busy_o),
    .id_err_o(id_err_o)
  );

  int passed = 0;
  int total  = 0;

  // LFSR reference: right-shift Galois, polynomial x^32+x^22+x^2+x+1
  logic [31:0] ref_lfsr;
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= SEED;
`ifdef SAES32_ISSUE_RESEED_EN
    else if (reseed_i) ref_lfsr <= (seed_i == 32'h0) ? SEED : seed_i;
`endif
    else ref_lfsr <= ref_lfsr[0] ? ((ref_lfsr >> 1) ^ 32'h80200003) : (ref_lfsr >> 1);
  end

  function automatic logic [31:0] fu_model(input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [1:0] bs, input logic dec);
    logic [31:0] sh;
    logic [7:0]  b, y;
    sh = rs2 >> (8 * bs);
    b  = sh[7:0];
    if (b == 8'h00) y = dec ? 8'h52 : 8'h63;
    else            y = b ^ 8'hA5;
    return rs1 ^ {y, 24'h0};
  endfunction

  logic          force_en  = 1'b0;
  logic [XW-1:0] force_val = '0;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bus.fu_valid_i    <= 1'b0;
      bus.fu_result_i   <= '0;
      bus.fu_instr_id_i <= '0;
    end else begin
      bus.fu_valid_i <= bus.fu_valid_o && bus.fu_ready_i;
      if (bus.fu_valid_o && bus.fu_ready_i) begin
        bus.fu_result_i   <= fu_model(bus.fu_rs1_o, bus.fu_rs2_o, bus.fu_bs_o,
                                      bus.fu_op_decs_o | bus.fu_op_decsm_o);
        bus.fu_instr_id_i <= force_en ? force_val : bus.fu_instr_id_o;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [XW-1:0] id, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [1:0] bs,
                       output bit acc, output logic [31:0] lf);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_id_i    = id;
    bus.req_rs1_i   = rs1;
    bus.req_rs2_i   = rs2;
    bus.req_bs_i    = bs;
    @(negedge clk_i);
    acc = bus.req_ready_o;
    lf  = ref_lfsr;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_res(output bit found, output logic [31:0] d, output logic [XW-1:0] id);
    found = 1'b0;
    d     = '0;
    id    = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk_i);
      if (bus.res_valid_o) begin
        found = 1'b1;
        d     = bus.res_data_o;
        id    = bus.res_id_o;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    total++; if ({bus.fu_valid_o, bus.res_valid_o, busy_o, id_err_o} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {bus.fu_valid_o, bus.res_valid_o, busy_o, id_err_o}); else passed++;
    total++; if ({bus.fu_randombits_o, bus.res_data_o, bus.fu_rs1_o} !== '0)
      $display("FAIL reset_data got %h/%h/%h want 0", bus.fu_randombits_o, bus.res_data_o, bus.fu_rs1_o); else passed++;
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    @(negedge clk_i);
    total++; if ({bus.fu_ready_o, bus.req_ready_o} !== 2'b11)
      $display("FAIL reset_ready got %b want 11", {bus.fu_ready_o, bus.req_ready_o}); else passed++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_encs();
    bit acc, found; logic [31:0] lf, d; logic [XW-1:0] id;
    issue(2'b00, 4'd3, 32'h0, 32'h0, 2'd0, acc, lf);
    total++; if (acc !== 1'b1) $display("FAIL encs_accept got %b want 1", acc); else passed++;
    total++; if ({bus.fu_valid_o, bus.fu_op_encs_o, bus.fu_op_encsm_o, bus.fu_op_decs_o, bus.fu_op_decsm_o} !== 5'b11000)
      $display("FAIL encs_issue got %b want 11000", {bus.fu_valid_o, bus.fu_op_encs_o, bus.fu_op_encsm_o, bus.fu_op_decs_o, bus.fu_op_decsm_o}); else passed++;
    total++; if (bus.fu_instr_id_o !== 4'd3) $display("FAIL encs_fu_id got %0d want 3", bus.fu_instr_id_o); else passed++;
    wait_res(found, d, id);
    total++; if ({found, d, id} !== {1'b1, 32'h63000000, 4'd3})
      $display("FAIL encs_result got %b %h %0d want 1 63000000 3", found, d, id); else passed++;
    total++; if ({busy_o, id_err_o} !== 2'b00) $display("FAIL encs_idle got %b want 00", {busy_o, id_err_o}); else passed++;
  endtask

  task automatic test_decs();
    bit acc, found; logic [31:0] lf, d; logic [XW-1:0] id;
    issue(2'b10, 4'd1, 32'h0000FFFF, 32'h0, 2'd0, acc, lf);
    total++; if ({acc, bus.fu_op_decs_o, bus.fu_op_encs_o} !== 3'b110)
      $display("FAIL decs_issue got %b want 110", {acc, bus.fu_op_decs_o, bus.fu_op_encs_o}); else passed++;
    wait_res(found, d, id);
    total++; if ({found, d, id} !== {1'b1, 32'h5200FFFF, 4'd1})
      $display("FAIL decs_result got %b %h %0d want 1 5200ffff 1", found, d, id); else passed++;
  endtask

  task automatic test_randombits();
    bit acc1, acc2, found; logic [31:0] lf1, lf2, d; logic [XW-1:0] id; logic [25:0] r1;
    issue(2'b00, 4'd4, 32'h1, 32'h0, 2'd0, acc1, lf1);
    r1 = bus.fu_randombits_o;
    total++; if (r1 !== lf1[25:0]) $display("FAIL rnd_first got %h want %h", r1, lf1[25:0]); else passed++;
    issue(2'b00, 4'd5, 32'h2, 32'h0, 2'd0, acc2, lf2);
    total++; if ({acc1, acc2} !== 2'b11) $display("FAIL rnd_b2b_accept got %b want 11", {acc1, acc2}); else passed++;
    total++; if (bus.fu_randombits_o !== lf2[25:0]) $display("FAIL rnd_second got %h want %h", bus.fu_randombits_o, lf2[25:0]); else passed++;
    total++; if (bus.fu_randombits_o === r1) $display("FAIL rnd_differs got %h want value other than %h", bus.fu_randombits_o, r1); else passed++;
    wait_res(found, d, id);
    total++; if ({found, d, id} !== {1'b1, 32'h63000001, 4'd4}) $display("FAIL rnd_res0 got %b %h %0d want 1 63000001 4", found, d, id); else passed++;
    wait_res(found, d, id);
    total++; if ({found, d, id} !== {1'b1, 32'h63000002, 4'd5}) $display("FAIL rnd_res1 got %b %h %0d want 1 63000002 5", found, d, id); else passed++;
  endtask

  task automatic test_stall();
    bit acc, found, ok; logic [31:0] lf, d; logic [XW-1:0] id;
    bus.fu_ready_i = 1'b0;
    issue(2'b01, 4'd6, 32'hDEADBEEF, 32'h12345678, 2'd2, acc, lf);
    total++; if ({acc, bus.fu_valid_o, bus.fu_op_encsm_o} !== 3'b111)
      $display("FAIL stall_issue got %b want 111", {acc, bus.fu_valid_o, bus.fu_op_encsm_o}); else passed++;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if ({bus.fu_valid_o, bus.fu_rs1_o, bus.fu_rs2_o, bus.fu_bs_o, bus.fu_randombits_o, bus.fu_instr_id_o, bus.req_ready_o}
          !== {1'b1, 32'hDEADBEEF, 32'h12345678, 2'd2, lf[25:0], 4'd6, 1'b0}) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) $display("FAIL stall_hold got unstable=%b want stable", !ok); else passed++;
    @(posedge clk_i); #1;
    bus.fu_ready_i = 1'b1;
    wait_res(found, d, id);
    total++; if ({found, d, id} !== {1'b1, 32'h4FADBEEF, 4'd6})
      $display("FAIL stall_result got %b %h %0d want 1 4fadbeef 6", found, d, id); else passed++;
  endtask

  task automatic test_credits();
    bit found, bp; logic [31:0] d; logic [XW-1:0] id; int acc_cnt;
    logic [XW-1:0] next_id;
    bus.res_ready_i = 1'b0;
    acc_cnt = 0; next_id = '0; bp = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = 2'b00;
      bus.req_id_i    = next_id;
      bus.req_rs1_i   = 32'(i);
      bus.req_rs2_i   = 32'h0;
      bus.req_bs_i    = 2'd0;
      @(negedge clk_i);
      if (bus.req_ready_o) begin acc_cnt++; next_id = next_id + 4'd1; end
      @(posedge clk_i); #1;
    end
    bus.req_valid_i = 1'b0;
    total++; if (acc_cnt !== DEPTH) $display("FAIL credit_accepts got %0d want %0d", acc_cnt, DEPTH); else passed++;
    total++; if (bus.req_ready_o !== 1'b0) $display("FAIL credit_ready got %b want 0", bus.req_ready_o); else passed++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (bus.fu_valid_i && !bus.fu_ready_o) bp = 1'b1;
    end
    total++; if ({bp, busy_o} !== 2'b01) $display("FAIL credit_hold got bp=%b busy=%b want bp=0 busy=1", bp, busy_o); else passed++;
    @(posedge clk_i); #1;
    bus.res_ready_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      wait_res(found, d, id);
      total++; if ({found, d, id} !== {1'b1, 32'h63000000 ^ 32'(k), 4'(k)})
        $display("FAIL credit_drain%0d got %b %h %0d want 1 %h %0d", k, found, d, id, 32'h63000000 ^ 32'(k), k); else passed++;
    end
    total++; if ({busy_o, bus.fu_ready_o, bus.req_ready_o} !== 3'b011)
      $display("FAIL credit_after got %b want 011", {busy_o, bus.fu_ready_o, bus.req_ready_o}); else passed++;
  endtask

  task automatic test_id_err();
    bit acc, found; logic [31:0] lf, d; logic [XW-1:0] id;
    bus.res_ready_i = 1'b0;
    force_en = 1'b1; force_val = 4'd5;
    issue(2'b00, 4'd2, 32'h0, 32'h0, 2'd0, acc, lf);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      if (bus.fu_valid_i) found = 1'b1;
    end
    total++; if ({found, id_err_o} !== 2'b10) $display("FAIL iderr_before got %b want 10", {found, id_err_o}); else passed++;
    @(negedge clk_i);
    total++; if (id_err_o !== 1'b1) $display("FAIL iderr_set got %b want 1", id_err_o); else passed++;
    @(posedge clk_i); #1;
    force_en = 1'b0;
    bus.res_ready_i = 1'b1;
    wait_res(found, d, id);
    total++; if ({found, d, id} !== {1'b1, 32'h63000000, 4'd5})
      $display("FAIL iderr_deliver got %b %h %0d want 1 63000000 5", found, d, id); else passed++;
    repeat (3) begin @(posedge clk_i); #1; end
    total++; if (id_err_o !== 1'b1) $display("FAIL iderr_sticky got %b want 1", id_err_o); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({id_err_o, busy_o} !== 2'b00) $display("FAIL iderr_reset got %b want 00", {id_err_o, busy_o}); else passed++;
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    @(posedge clk_i); #1;
  endtask

`ifdef SAES32_ISSUE_RESEED_EN
  task automatic test_reseed();
    bit acc1, acc2, found; logic [31:0] lf1, lf2, d, sv; logic [XW-1:0] id;
    sv = SEED;
    repeat (3) begin @(posedge clk_i); #1; end
    reseed_i = 1'b1; seed_i = 32'h0;
    issue(2'b00, 4'd7, 32'h0, 32'h0, 2'd0, acc1, lf1);
    reseed_i = 1'b0;
    total++; if (bus.fu_randombits_o !== lf1[25:0]) $display("FAIL reseed_pre got %h want %h", bus.fu_randombits_o, lf1[25:0]); else passed++;
    issue(2'b00, 4'd8, 32'h0, 32'h0, 2'd0, acc2, lf2);
    total++; if (bus.fu_randombits_o !== sv[25:0]) $display("FAIL reseed_seed got %h want %h", bus.fu_randombits_o, sv[25:0]); else passed++;
    wait_res(found, d, id);
    wait_res(found, d, id);
    total++; if ({found, id} !== {1'b1, 4'd8}) $display("FAIL reseed_drain got %b %0d want 1 8", found, id); else passed++;
  endtask
`endif

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_rs1_i   = '0;
    bus.req_rs2_i   = '0;
    bus.req_bs_i    = '0;
    bus.req_op_i    = '0;
    bus.req_id_i    = '0;
    bus.fu_ready_i  = 1'b1;
    bus.res_ready_i = 1'b1;
    test_reset();
    test_encs();
    test_decs();
    test_randombits();
    test_stall();
    test_credits();
    test_id_err();
`ifdef SAES32_ISSUE_RESEED_EN
    test_reseed();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
